// File: rtl/proc_pkg.sv
// Opcode and FSM state definitions shared by the param_proc_core slice.
package proc_pkg;

  localparam logic [2:0] OP_MV   = 3'd0;
  localparam logic [2:0] OP_MVI  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_OR   = 3'd5;
  localparam logic [2:0] OP_MVNZ = 3'd6;
  localparam logic [2:0] OP_ILL  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_T1   = 2'd1,
    ST_T2   = 2'd2,
    ST_T3   = 2'd3
  } state_t;

endpackage

// File: rtl/proc_alu.sv
// Combinational ALU; the op select is the low two opcode bits (add/sub/and/or are unique there).
module proc_alu
  import proc_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [1:0]        i_op,
  output logic [DATA_W-1:0] o_y
);

  always_comb begin
    case (i_op)
      OP_ADD[1:0]: o_y = i_a + i_b;
      OP_SUB[1:0]: o_y = i_a - i_b;
      OP_AND[1:0]: o_y = i_a & i_b;
      default:     o_y = i_a | i_b;
    endcase
  end

endmodule

// File: rtl/param_proc_core.sv
// Multi-cycle accumulator-bus processor: IR/A/G registers, NREGS-entry register file,
// one-hot bus mux and a four-state control FSM with Busy/Done handshake.
module param_proc_core
  import proc_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int NREGS  = 4,
  localparam int REG_AW = $clog2(NREGS),
  localparam int IR_W   = 3 + 2*REG_AW
) (
  input  logic                    Clk,
  input  logic                    Resetn,
  input  logic                    Run,
  input  logic [DATA_W-1:0]       DIN,
  output logic                    Busy,
  output logic                    Done,
  output logic                    Err,
  output logic                    Zflag,
  output logic [IR_W-1:0]         IR,
  output logic [DATA_W-1:0]       G,
  output logic [DATA_W-1:0]       Bus,
  output logic [NREGS*DATA_W-1:0] Rflat
);

  state_t              r_state, w_next;
  logic [IR_W-1:0]     r_ir;
  logic [DATA_W-1:0]   r_a, r_g;
  logic                r_err;
  logic [DATA_W-1:0]   w_regs [NREGS];
  logic [DATA_W-1:0]   w_bus, w_alu;
  logic [2:0]          w_op;
  logic [REG_AW-1:0]   w_rx, w_ry;
  logic                w_zero;
  logic                w_sel_din, w_sel_rx, w_sel_ry, w_sel_g;
  logic                w_ir_we, w_a_we, w_g_we, w_r_we, w_err_set, w_done;

  assign w_op   = r_ir[IR_W-1 -: 3];
  assign w_rx   = r_ir[2*REG_AW-1 -: REG_AW];
  assign w_ry   = r_ir[REG_AW-1:0];
  assign w_zero = (r_g == '0);

  always_comb begin
    w_next    = r_state;
    w_sel_din = 1'b0;
    w_sel_rx  = 1'b0;
    w_sel_ry  = 1'b0;
    w_sel_g   = 1'b0;
    w_ir_we   = 1'b0;
    w_a_we    = 1'b0;
    w_g_we    = 1'b0;
    w_r_we    = 1'b0;
    w_err_set = 1'b0;
    w_done    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (Run) begin
          w_ir_we = 1'b1;
          w_next  = ST_T1;
        end
      end
      ST_T1: begin
        w_next = ST_IDLE;
        w_done = 1'b1;
        case (w_op)
          OP_MV: begin
            w_sel_ry = 1'b1;
            w_r_we   = 1'b1;
          end
          OP_MVI: begin
            w_sel_din = 1'b1;
            w_r_we    = 1'b1;
          end
          OP_MVNZ: begin
            w_sel_ry = 1'b1;
            w_r_we   = !w_zero;
          end
          OP_ILL: w_err_set = 1'b1;
          default: begin
            w_sel_rx = 1'b1;
            w_a_we   = 1'b1;
            w_done   = 1'b0;
            w_next   = ST_T2;
          end
        endcase
      end
      ST_T2: begin
        w_sel_ry = 1'b1;
        w_g_we   = 1'b1;
        w_next   = ST_T3;
      end
      default: begin
        w_sel_g = 1'b1;
        w_r_we  = 1'b1;
        w_done  = 1'b1;
        w_next  = ST_IDLE;
      end
    endcase
  end

  // Every register write takes its data from the bus, so one write port covers mv/mvi/mvnz/T3.
  assign w_bus = ({DATA_W{w_sel_din}} & DIN)
               | ({DATA_W{w_sel_rx}}  & w_regs[w_rx])
               | ({DATA_W{w_sel_ry}}  & w_regs[w_ry])
               | ({DATA_W{w_sel_g}}   & r_g);

  proc_alu #(.DATA_W(DATA_W)) u_alu (
    .i_a  (r_a),
    .i_b  (w_bus),
    .i_op (w_op[1:0]),
    .o_y  (w_alu)
  );

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      r_state <= ST_IDLE;
      r_ir    <= '0;
      r_a     <= '0;
      r_g     <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_ir_we)   r_ir  <= DIN[IR_W-1:0];
      if (w_a_we)    r_a   <= w_bus;
      if (w_g_we)    r_g   <= w_alu;
      if (w_err_set) r_err <= 1'b1;
    end
  end

  for (genvar k = 0; k < NREGS; k++) begin : g_reg
    logic [DATA_W-1:0] r_q;
    always_ff @(posedge Clk or negedge Resetn) begin
      if (!Resetn)                               r_q <= '0;
      else if (w_r_we && (w_rx == REG_AW'(k)))  r_q <= w_bus;
    end
    assign w_regs[k]                 = r_q;
    assign Rflat[k*DATA_W +: DATA_W] = r_q;
  end

  assign Busy  = (r_state != ST_IDLE);
  assign Done  = w_done;
  assign Err   = r_err;
  assign Zflag = w_zero;
  assign IR    = r_ir;
  assign G     = r_g;
  assign Bus   = w_bus;

endmodule
